alu_share_ctrl: RTL and testbench

- Time-multiplexes one combinational PE ALU between NUM_REQ requesters. Supported ops: ADD/SUB/AND/OR/XOR/MUL.
- Arbitrates requests round-robin and registers the granted operands and function into the ALU inputs.
- Captures the ALU result and returns it on a single tagged response channel with a valid/ready handshake.
- Sits inside the PE tile between the routing fabric and the ALU.

---
 rtl/alu_share_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the round-robin ALU sharing controller: op codes and FSM states.
package alu_share_pkg;

    localparam int unsigned ADD    = 0;
    localparam int unsigned SUB    = 1;
    localparam int unsigned AND    = 2;
    localparam int unsigned OR     = 3;
    localparam int unsigned XOR    = 4;
    localparam int unsigned MUL    = 5;
    localparam int unsigned OP_MAX = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request after index 'last', wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = IW'((int'(last) + k) % int'(N));
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-multiplexes one combinational ALU between NUM_REQ requesters with a tagged response channel.
// Define ALU_SHARE_ILLEGAL_TRAP_EN to answer func codes above OP_MAX with rsp_err instead of issuing.
module alu_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNC_W  = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FUNC_W-1:0] req_func,
    input  logic [NUM_REQ*WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*WIDTH-1:0]  req_b,
    output logic [FUNC_W-1:0]         alu_func,
    output logic [WIDTH-1:0]          alu_in1,
    output logic [WIDTH-1:0]          alu_in2,
    input  logic [WIDTH-1:0]          alu_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
    output logic                      rsp_err,
`endif
    output logic [WIDTH-1:0]          rsp_data
);

    import alu_share_pkg::*;

    state_t state_q, state_d;

    logic [ID_W-1:0]    last_q, id_q, rsp_id_q;
    logic [FUNC_W-1:0]  alu_func_q;
    logic [WIDTH-1:0]   alu_in1_q, alu_in2_q, rsp_data_q;
    logic               rsp_valid_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any, can_accept, accept;
    logic [FUNC_W-1:0]  sel_func;
    logic [WIDTH-1:0]   sel_a, sel_b;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .last     (last_q),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (grant_any)
    );

    always_comb begin
        sel_func = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_func = req_func[i*FUNC_W +: FUNC_W];
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // RESP can take a new request in the same cycle its response is consumed.
    assign can_accept = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign accept     = can_accept && grant_any;
    assign req_ready  = can_accept ? grant : '0;

`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
    logic illegal;
    logic rsp_err_q;
    assign illegal = 32'(sel_func) > OP_MAX;
    assign rsp_err = rsp_err_q;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
        if (accept && illegal) state_d = RESP;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            alu_func_q  <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == EXEC) begin
                rsp_data_q  <= alu_out;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
                rsp_err_q   <= 1'b0;
`endif
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (accept) begin
                last_q <= grant_idx;
                id_q   <= grant_idx;
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
                if (illegal) begin
                    rsp_data_q  <= '0;
                    rsp_id_q    <= grant_idx;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                end else begin
                    alu_func_q <= sel_func;
                    alu_in1_q  <= sel_a;
                    alu_in2_q  <= sel_b;
                end
`else
                alu_func_q <= sel_func;
                alu_in1_q  <= sel_a;
                alu_in2_q  <= sel_b;
`endif
            end
        end
    end

    assign alu_func  = alu_func_q;
    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus randomized traffic vs a
// transaction-level model. Honours ALU_SHARE_ILLEGAL_TRAP_EN when defined.
module tb_alu_share_ctrl;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int FW = 3;
    localparam int IW = 2;
    localparam logic [FW-1:0] F_ADD = 3'd0, F_SUB = 3'd1, F_XOR = 3'd4, F_MUL = 3'd5;
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*FW-1:0] req_func;
    logic [NR*W-1:0]  req_a, req_b;
    logic [FW-1:0]    alu_func;
    logic [W-1:0]     alu_in1, alu_in2, alu_out, rsp_data;
    logic             rsp_valid, rsp_ready;
    logic [IW-1:0]    rsp_id;
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
    logic             rsp_err;
`endif

    // Requester-side state: each holds its op until accepted.
    logic [NR-1:0] v;
    logic [FW-1:0] f [NR];
    logic [W-1:0]  a [NR];
    logic [W-1:0]  b [NR];

    always_comb begin
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_func[i*FW +: FW] = f[i];
            req_a[i*W +: W]      = a[i];
            req_b[i*W +: W]      = b[i];
        end
    end

    function automatic logic [W-1:0] ref_alu(input logic [FW-1:0] fn, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = 64'(x) * 64'(y);
        case (fn)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return p[W-1:0];
            default: return '0;
        endcase
    endfunction

    always_comb alu_out = ref_alu(alu_func, alu_in1, alu_in2);

    alu_share_ctrl #(
        .NUM_REQ(NR),
        .WIDTH  (W),
        .FUNC_W (FW),
        .ID_W   (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_func (req_func),
        .req_a    (req_a),
        .req_b    (req_b),
        .alu_func (alu_func),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_out  (alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
        .rsp_err  (rsp_err),
`endif
        .rsp_data (rsp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one op in the ALU at most, one pending response at most.
    int          m_last;
    bit          m_exec_v, m_rsp_v, m_rsp_err;
    int          m_exec_id, m_rsp_id;
    logic [W-1:0] m_exec_data, m_rsp_data;
    int unsigned  log_id[$];
    logic [W-1:0] log_data[$];

    task automatic step(input bit do_rst);
        int gi;
        bit hs;
        logic [NR-1:0] eg;
        #1;
        gi = -1;
        eg = '0;
        if (!do_rst && !m_exec_v && (!m_rsp_v || rsp_ready)) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_last + k) % NR;
                if (gi < 0 && v[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        if (!do_rst) check_eq("req_ready", req_ready, eg);
        hs = !do_rst && m_rsp_v && rsp_ready;
        rst = do_rst;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (do_rst) begin
            m_last    = NR - 1;
            m_exec_v  = 1'b0;
            m_rsp_v   = 1'b0;
            m_rsp_err = 1'b0;
        end else begin
            if (hs) begin
                log_id.push_back(m_rsp_id);
                log_data.push_back(m_rsp_data);
                m_rsp_v = 1'b0;
            end
            if (m_exec_v) begin
                m_rsp_v    = 1'b1;
                m_rsp_id   = m_exec_id;
                m_rsp_data = m_exec_data;
                m_rsp_err  = 1'b0;
                m_exec_v   = 1'b0;
            end
            if (gi >= 0) begin
                m_last = gi;
                v[gi]  = 1'b0;
                if (TRAP && f[gi] > 3'd5) begin
                    m_rsp_v    = 1'b1;
                    m_rsp_id   = gi;
                    m_rsp_data = '0;
                    m_rsp_err  = 1'b1;
                end else begin
                    m_exec_v    = 1'b1;
                    m_exec_id   = gi;
                    m_exec_data = ref_alu(f[gi], a[gi], b[gi]);
                end
            end
        end
        check_eq("rsp_valid", rsp_valid, m_rsp_v);
        if (m_rsp_v) begin
            check_eq("rsp_id", rsp_id, m_rsp_id);
            check_eq("rsp_data", rsp_data, m_rsp_data);
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
            check_eq("rsp_err", rsp_err, m_rsp_err);
`endif
        end
    endtask

    task automatic do_reset();
        v = '0;
        rsp_ready = 1'b0;
        step(1'b1);
        step(1'b1);
        log_id.delete();
        log_data.delete();
    endtask

    task automatic set_op(input int i, input logic [FW-1:0] fn, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        v[i] = 1'b1;
        f[i] = fn;
        a[i] = x;
        b[i] = y;
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            f[i] = '0;
            a[i] = '0;
            b[i] = '0;
        end
        m_last = NR - 1;
        m_exec_v = 1'b0;
        m_rsp_v = 1'b0;
        m_rsp_err = 1'b0;
        m_exec_id = 0;
        m_rsp_id = 0;
        m_exec_data = '0;
        m_rsp_data = '0;
        do_reset();

        check_eq("rst_alu_func", alu_func, 0);
        check_eq("rst_alu_in1", alu_in1, 0);
        check_eq("rst_alu_in2", alu_in2, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_id", rsp_id, 0);

        // Single ADD: one cycle in EXEC, then the response.
        set_op(0, F_ADD, 32'd5, 32'd7);
        rsp_ready = 1'b1;
        step(1'b0);
        check_eq("single_exec_no_rsp", rsp_valid, 0);
        step(1'b0);
        check_eq("single_rsp_valid", rsp_valid, 1);
        check_eq("single_data", rsp_data, 32'd12);
        check_eq("single_id", rsp_id, 0);
        step(1'b0);

        // Round-robin with every requester continuously valid.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, F_XOR, W'(i), 32'hF0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(1'b0);
            for (int i = 0; i < NR; i++) if (!v[i]) set_op(i, F_XOR, W'(i), 32'hF0);
        end
        check_eq("rr_count_ge5", 64'(log_id.size() >= 5), 1);
        for (int k = 0; k < 5 && k < log_id.size(); k++) begin
            check_eq("rr_order", log_id[k], k % NR);
            check_eq("rr_data", log_data[k], 32'hF0 ^ W'(k % NR));
        end

        // Backpressure: response held, no accepts until it is consumed.
        do_reset();
        set_op(1, F_SUB, 32'd3, 32'd5);
        step(1'b0);
        step(1'b0);
        set_op(2, F_ADD, 32'd1, 32'd1);
        for (int c = 0; c < 5; c++) begin
            step(1'b0);
            check_eq("bp_hold_data", rsp_data, 32'hFFFF_FFFE);
            check_eq("bp_hold_id", rsp_id, 1);
            check_eq("bp_hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step(1'b0);
        check_eq("bp_resume_accept", v[2], 0);
        step(1'b0);
        check_eq("bp_resume_data", rsp_data, 32'd2);
        check_eq("bp_resume_id", rsp_id, 2);
        step(1'b0);

        // MUL truncation to WIDTH.
        do_reset();
        set_op(3, F_MUL, 32'h1_0000, 32'h1_0000);
        rsp_ready = 1'b1;
        step(1'b0);
        step(1'b0);
        check_eq("mul_valid", rsp_valid, 1);
        check_eq("mul_trunc", rsp_data, 0);
        step(1'b0);

        // Reset while the op sits in EXEC.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, F_ADD, W'(i + 10), W'(i));
        rsp_ready = 1'b1;
        step(1'b0);
        step(1'b1);
        check_eq("midrst_valid", rsp_valid, 0);
        check_eq("midrst_alu_in1", alu_in1, 0);
        check_eq("midrst_alu_in2", alu_in2, 0);
        check_eq("midrst_alu_func", alu_func, 0);
        set_op(0, F_ADD, 32'd10, 32'd0);
        #1;
        check_eq("midrst_regrant0", req_ready, 4'b0001);
        for (int c = 0; c < 6; c++) step(1'b0);
        check_eq("midrst_first_id", (log_id.size() > 0) ? 64'(log_id[0]) : 64'hDEAD, 0);

        // Illegal function code from requester 2.
        do_reset();
        set_op(1, F_ADD, 32'h1234, 32'd1);
        rsp_ready = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        set_op(2, 3'd7, 32'hABCD, 32'd3);
        step(1'b0);
`ifdef ALU_SHARE_ILLEGAL_TRAP_EN
        check_eq("ill_valid", rsp_valid, 1);
        check_eq("ill_err", rsp_err, 1);
        check_eq("ill_data", rsp_data, 0);
        check_eq("ill_id", rsp_id, 2);
        check_eq("ill_alu_in1", alu_in1, 32'h1234);
`else
        step(1'b0);
        check_eq("ill_valid", rsp_valid, 1);
        check_eq("ill_data", rsp_data, 0);
        check_eq("ill_id", rsp_id, 2);
        check_eq("ill_alu_in1", alu_in1, 32'hABCD);
`endif
        step(1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0)
                    set_op(i, FW'($urandom_range(0, 7)), $urandom,
                           ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
